// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared MaxNet constants, controller FSM state enum and result status enum
package maxnet_pkg;
  localparam int N_NEURON = 4;
  localparam int DATA_W = 32;
  localparam int MAX_ITER = 255;
  typedef enum logic [2:0] {S_IDLE, S_MULT, S_SUM, S_CHECK, S_DONE} state_t;
  typedef enum logic [1:0] {NONE_YET = 2'd0, WINNER = 2'd1, ALL_ZERO = 2'd2, TIMEOUT = 2'd3} status_t;
endpackage

// File: rtl/maxnet_controller_winner_detect.sv
// winner_detect: counts zero bits of pu_s (live neurons) into nz_count and reports the lowest live index as first_nz_idx
module winner_detect
  import maxnet_pkg::*;
#(
  parameter int N = N_NEURON,
  parameter int IDX_W = 2,
  parameter int CNT_W = 3
) (
  input  logic [N-1:0]     pu_s,
  output logic [CNT_W-1:0] nz_count,
  output logic [IDX_W-1:0] first_nz_idx
);
  always_comb begin
    nz_count = '0;
    first_nz_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (!pu_s[i]) begin
        nz_count = nz_count + 1'b1;
        first_nz_idx = IDX_W'(i);
      end
  end
endmodule

// File: rtl/maxnet_controller.sv
// maxnet_controller: sequences MULT/SUM/CHECK rounds over external ProcessUnits (clock, reset, start, x_in, pu_out, pu_s in; x_pu, load_mult, load_sum, busy, done, status, winner_idx, winner_val, iter_count out)
module maxnet_controller #(
  parameter int N_NEURON = maxnet_pkg::N_NEURON,
  parameter int DATA_W = maxnet_pkg::DATA_W,
  parameter int MAX_ITER = maxnet_pkg::MAX_ITER,
  localparam int IDX_W = N_NEURON > 1 ? $clog2(N_NEURON) : 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [N_NEURON-1:0][DATA_W-1:0]  x_in,
  input  logic [N_NEURON-1:0][DATA_W-1:0]  pu_out,
  input  logic [N_NEURON-1:0]              pu_s,
  output logic [N_NEURON-1:0][DATA_W-1:0]  x_pu,
  output logic                             load_mult,
  output logic                             load_sum,
  output logic                             busy,
  output logic                             done,
  output logic [1:0]                       status,
  output logic [IDX_W-1:0]                 winner_idx,
  output logic [DATA_W-1:0]                winner_val,
  output logic [7:0]                       iter_count
);
  import maxnet_pkg::*;
  localparam int CNT_W = $clog2(N_NEURON + 1);
  state_t state;
  logic [CNT_W-1:0] nz_count;
  logic [IDX_W-1:0] first_nz;
  logic one, zero, last_iter;
  winner_detect #(.N(N_NEURON), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_detect (
    .pu_s(pu_s),
    .nz_count(nz_count),
    .first_nz_idx(first_nz)
  );
  assign one = nz_count == CNT_W'(1);
  assign zero = nz_count == '0;
  assign last_iter = 9'(iter_count) + 9'd1 == 9'(MAX_ITER);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      x_pu <= '0;
      load_mult <= 1'b0;
      load_sum <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      status <= NONE_YET;
      winner_idx <= '0;
      winner_val <= '0;
      iter_count <= '0;
    end else begin
      load_mult <= 1'b0;
      load_sum <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          x_pu <= x_in;
          iter_count <= '0;
          status <= NONE_YET;
          winner_idx <= '0;
          winner_val <= '0;
          load_mult <= 1'b1;
          busy <= 1'b1;
          state <= S_MULT;
        end
        S_MULT: begin
          load_sum <= 1'b1;
          state <= S_SUM;
        end
        S_SUM: state <= S_CHECK;
        S_CHECK: begin
          x_pu <= pu_out;
          iter_count <= iter_count + 8'd1;
          // a single survivor wins even on the last permitted iteration
          if (one || zero || last_iter) begin
            status <= one ? WINNER : zero ? ALL_ZERO : TIMEOUT;
            winner_idx <= one ? first_nz : '0;
            winner_val <= one ? pu_out[first_nz] : '0;
            done <= 1'b1;
            state <= S_DONE;
          end else begin
            load_mult <= 1'b1;
            state <= S_MULT;
          end
        end
        S_DONE: begin
          busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maxnet_controller.sv
// tb_maxnet_controller: table-driven and sequence checks of maxnet_controller against a ProcessUnit stub
module tb_maxnet_controller;
  localparam int N = 4;
  localparam int W = 32;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [N-1:0][W-1:0] x_in, pu_out, x_pu;
  logic [N-1:0] pu_s;
  logic load_mult, load_sum, busy, done;
  logic [1:0] status, winner_idx;
  logic [W-1:0] winner_val;
  logic [7:0] iter_count;
  maxnet_controller #(.N_NEURON(N), .DATA_W(W), .MAX_ITER(3)) dut (
    .clock(clock), .reset(reset), .start(start), .x_in(x_in), .pu_out(pu_out), .pu_s(pu_s),
    .x_pu(x_pu), .load_mult(load_mult), .load_sum(load_sum), .busy(busy), .done(done),
    .status(status), .winner_idx(winner_idx), .winner_val(winner_val), .iter_count(iter_count)
  );
  typedef struct {
    logic [N-1:0][W-1:0] x;
    logic [N-1:0][W-1:0] po;
    logic [N-1:0] s;
    logic [1:0] st;
    logic [1:0] idx;
    logic [W-1:0] val;
  } vec_t;
  vec_t vecs[5];
  logic [N-1:0] stub_s[4];
  logic [N-1:0][W-1:0] stub_o[4];
  int n_sum = 0, base = 0, applied = 0, errors = 0, done_cnt = 0, overlap = 0, cyc, sel;
  always #5 clock = ~clock;
  always_comb begin
    sel = n_sum - base - 1;
    if (sel < 0) sel = 0;
    if (sel > 3) sel = 3;
    pu_s = stub_s[sel];
    pu_out = stub_o[sel];
  end
  always @(negedge clock) begin
    if (load_sum) n_sum++;
    if (done) done_cnt++;
    if (load_mult && load_sum) overlap++;
  end
  function automatic logic [N-1:0][W-1:0] pk(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task tick;
    @(posedge clock);
    #1;
  endtask
  task automatic stub_all(input logic [N-1:0] s, input logic [N-1:0][W-1:0] o);
    for (int i = 0; i < 4; i++) begin
      stub_s[i] = s;
      stub_o[i] = o;
    end
  endtask
  task automatic run(input logic [N-1:0][W-1:0] x, input logic hold, input int exp_cyc);
    x_in = x;
    base = n_sum;
    start = 1'b1;
    tick;
    chk("x_captured", x_pu, x);
    chk("busy_in_mult", busy, 1);
    chk("load_mult_first", load_mult, 1);
    start = hold;
    cyc = 1;
    while (!done && cyc < 40) begin
      tick;
      cyc++;
    end
    start = 1'b0;
    chk("done_cycle", cyc, exp_cyc);
  endtask
  initial begin
    x_in = '0;
    stub_all('1, '0);
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_load_mult", load_mult, 0);
    chk("rst_load_sum", load_sum, 0);
    chk("rst_status", status, 0);
    chk("rst_winner_idx", winner_idx, 0);
    chk("rst_winner_val", winner_val, 0);
    chk("rst_iter_count", iter_count, 0);
    chk("rst_x_pu", x_pu, 0);
    reset = 1'b0;
    tick;
    vecs[0] = '{pk(3, 5, 2, 1), pk(0, 5, 0, 0), 4'b1101, 2'd1, 2'd1, 32'd5};
    vecs[1] = '{pk(4, 4, 4, 4), pk(0, 0, 0, 0), 4'b1111, 2'd2, 2'd0, 32'd0};
    vecs[2] = '{pk(9, 1, 1, 1), pk(9, 0, 0, 0), 4'b1110, 2'd1, 2'd0, 32'd9};
    vecs[3] = '{pk(1, 2, 3, 32'hFFFF_FFFF), pk(0, 0, 0, 32'hFFFF_FFFF), 4'b0111, 2'd1, 2'd3, 32'hFFFF_FFFF};
    vecs[4] = '{pk(7, 0, 12, 3), pk(0, 0, 12, 0), 4'b1011, 2'd1, 2'd2, 32'd12};
    for (int v = 0; v < 5; v++) begin
      stub_all(vecs[v].s, vecs[v].po);
      run(vecs[v].x, 1'b0, 4);
      chk("vec_status", status, vecs[v].st);
      chk("vec_winner_idx", winner_idx, vecs[v].idx);
      chk("vec_winner_val", winner_val, vecs[v].val);
      chk("vec_iter_count", iter_count, 1);
      chk("vec_x_pu_from_pu_out", x_pu, vecs[v].po);
      tick;
      chk("vec_done_one_cycle", done, 0);
      chk("vec_idle_busy", busy, 0);
      chk("vec_status_held", status, vecs[v].st);
      chk("vec_val_held", winner_val, vecs[v].val);
    end
    stub_s[0] = 4'b1100; stub_o[0] = pk(4, 3, 0, 0);
    stub_s[1] = 4'b1100; stub_o[1] = pk(2, 1, 0, 0);
    stub_s[2] = 4'b1011; stub_o[2] = pk(0, 0, 7, 0);
    stub_s[3] = 4'b1011; stub_o[3] = pk(0, 0, 7, 0);
    run(pk(8, 6, 1, 1), 1'b1, 10);
    chk("iter3_status", status, 1);
    chk("iter3_winner_idx", winner_idx, 2);
    chk("iter3_winner_val", winner_val, 7);
    chk("iter3_iter_count", iter_count, 3);
    tick;
    chk("start_in_done_ignored", busy, 0);
    chk("iter3_done_low", done, 0);
    chk("iter3_done_pulses", done_cnt, 6);
    stub_all(4'b1100, pk(5, 5, 0, 0));
    x_in = pk(1, 2, 3, 4);
    base = n_sum;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    chk("mid_in_sum_iter2", load_sum, 1);
    chk("mid_iter_before_reset", iter_count, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_status", status, 0);
    chk("mid_x_pu", x_pu, 0);
    chk("mid_iter_count", iter_count, 0);
    chk("mid_load_mult", load_mult, 0);
    chk("mid_load_sum", load_sum, 0);
    chk("mid_winner_idx", winner_idx, 0);
    chk("mid_winner_val", winner_val, 0);
    repeat (3) tick;
    chk("mid_stays_idle", busy, 0);
    chk("mid_no_done", done_cnt, 6);
    stub_all(vecs[0].s, vecs[0].po);
    run(vecs[0].x, 1'b0, 4);
    chk("fresh_status", status, 1);
    chk("fresh_winner_idx", winner_idx, 1);
    chk("fresh_winner_val", winner_val, 5);
    chk("fresh_iter_count", iter_count, 1);
    tick;
    stub_all(4'b1100, pk(6, 6, 0, 0));
    run(pk(6, 6, 0, 0), 1'b0, 10);
    chk("timeout_status", status, 3);
    chk("timeout_winner_idx", winner_idx, 0);
    chk("timeout_winner_val", winner_val, 0);
    chk("timeout_iter_count", iter_count, 3);
    tick;
    chk("total_done_pulses", done_cnt, 8);
    chk("load_onehot", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end
endmodule

// File: doc/maxnet_controller.md
MAXNET_CONTROLLER -- requirements
Module: maxnet_controller

Interface
REQ-001 Parameter N_NEURON, default 4: number of ProcessUnit instances sequenced.
REQ-002 Parameter DATA_W, default 32: width of every activation value.
REQ-003 Parameter MAX_ITER, default 255: iteration limit before the controller gives up.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clock  in  1  rising-edge clock shared with all ProcessUnits.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request to begin a new competition, sampled only in IDLE.
REQ-008 x_in  in  N_NEURON x DATA_W  initial activations, captured when start is accepted.
REQ-009 pu_out  in  N_NEURON x DATA_W  rectified ProcessUnit outputs.
REQ-010 pu_s  in  N_NEURON  ProcessUnit zero flags (1 = output is zero).
REQ-011 x_pu  out  N_NEURON x DATA_W  activation registers driving the ProcessUnit x inputs.
REQ-012 load_mult  out  1  ProcessUnit multiply-stage load strobe.
REQ-013 load_sum  out  1  ProcessUnit sum-stage load strobe.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse marking a completed competition.
REQ-016 status  out  2  result code: 0 NONE_YET, 1 WINNER, 2 ALL_ZERO, 3 TIMEOUT.
REQ-017 winner_idx  out  clog2(N_NEURON)  index of the surviving neuron.
REQ-018 winner_val  out  DATA_W  final activation of the surviving neuron.
REQ-019 iter_count  out  8  number of iterations completed in the current or last run.

Function
REQ-020 The FSM SHALL have the states IDLE, MULT, SUM, CHECK and DONE.
REQ-021 IDLE with start=1: x_pu <= x_in, iter_count <= 0, status <= NONE_YET, and the next state is MULT.
REQ-022 MULT: load_mult=1 for exactly one cycle, then the next state is SUM.
REQ-023 SUM: load_sum=1 for exactly one cycle, then the next state is CHECK.
REQ-024 load_mult and load_sum SHALL never be high in the same cycle and SHALL be 0 outside MULT and SUM.
REQ-025 CHECK: x_pu <= pu_out, iter_count <= iter_count+1, and the nonzero count is taken as the number of pu_s bits equal to 0.
REQ-026 CHECK with exactly one nonzero neuron: status=WINNER, winner_idx = that index, winner_val = its pu_out, then DONE.
REQ-027 CHECK with zero nonzero neurons: status=ALL_ZERO, winner_idx=0, winner_val=0, then DONE.
REQ-028 CHECK with more than one nonzero neuron when iter_count+1 = MAX_ITER: status=TIMEOUT, winner_idx=0, winner_val=0, then DONE.
REQ-029 CHECK otherwise: the next state is MULT; equal nonzero values keep the competition running.
REQ-030 WINNER SHALL take precedence over TIMEOUT when both hold in the same CHECK.
REQ-031 DONE: done=1 for one cycle, then the next state is IDLE.
REQ-032 status, winner_idx, winner_val and iter_count SHALL hold until the next accepted start.
REQ-033 Timing: if start is sampled in cycle 0 and the run takes k iterations, done SHALL be high in cycle 3k+1.
REQ-034 start SHALL be ignored outside IDLE, including during the DONE cycle.
REQ-035 x_pu SHALL remain stable from MULT through SUM so that the ProcessUnit products match the registered activations.

Reset
REQ-036 reset SHALL take priority over start and every FSM transition.
REQ-037 On reset: state=IDLE, x_pu=0, load_mult=0, load_sum=0, busy=0, done=0, status=NONE_YET, winner_idx=0, winner_val=0, iter_count=0.
REQ-038 Reset asserted mid-run SHALL abort the run without a done pulse; the next start SHALL begin a fresh run.

Structure
REQ-039 A shared package maxnet_pkg SHALL hold N_NEURON, DATA_W, MAX_ITER, the FSM state enum and the status enum.
REQ-040 Nonzero counting and winner-index selection SHALL be placed in one combinational sub-module, winner_detect (inputs pu_s; outputs nz_count and first_nz_idx).
REQ-041 ProcessUnit instances SHALL be outside this block; the testbench ties the two together.

Verification
REQ-042 Single survivor: start with x_in={3,5,2,1}; a stub returns pu_out={0,5,0,0} and pu_s=4'b1101 at the first CHECK -> done in cycle 4, status=WINNER, winner_idx=1, winner_val=5, iter_count=1.
REQ-043 Three iterations: the stub returns two nonzero neurons for two CHECKs, then only neuron 2 = 7 -> done in cycle 10, winner_idx=2, winner_val=7, iter_count=3.
REQ-044 All zero: the stub returns pu_s=4'b1111 -> status=ALL_ZERO, winner_idx=0, winner_val=0, done in cycle 4.
REQ-045 Timeout: MAX_ITER=3 and the stub always returns two equal nonzero neurons -> status=TIMEOUT in cycle 10, iter_count=3.
REQ-046 Reset mid-run: reset asserted during SUM of iteration 2 -> the next cycle has IDLE with all outputs zero and no done; a new start then completes normally.
REQ-047 Protocol checks: start asserted during busy and during DONE is ignored; a one-hot check on load_mult and load_sum holds in every cycle.
